spi_host: RTL and testbench

- SPI controller (initiator) that sends waveform-select commands to the FPGA wavegen client over the same 3-wire link: `spi_clk`, `mosi`, `cs`.
- Accepts a 4-bit command through a valid/ready handshake, frames it, and shifts it out MSB-first in SPI mode 0.
- Used in the test harness and the companion controller FPGA to drive the wavegen board.

---
 rtl/spi_wavegen_pkg.sv | 27 ++
 rtl/spi_half_tick.sv | 49 ++++
 rtl/spi_host.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_host.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_wavegen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_wavegen_pkg
//  Description : Shared types and default constants for the wavegen SPI
//                link: the host FSM state encoding and the default command
//                and frame widths.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_wavegen_pkg;

  // Default command width, matches the client's waveform selector.
  localparam int CMD_W_DEF      = 4;
  // Default number of bits per SPI frame.
  localparam int FRAME_BITS_DEF = 8;

  // Host framing FSM.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4,
    GAP   = 3'd5
  } spi_host_state_t;

endpackage : spi_wavegen_pkg
`default_nettype wire

// File: rtl/spi_half_tick.sv
`default_nettype none
// ============================================================================
//  Module      : spi_half_tick
//  Description : Loadable down-counter timing one SPI half-period. After a
//                load, tick is high in the CLK_DIV-th cycle (counting the
//                first cycle after the load as cycle 1).
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                load - reload the counter (asserted on state transitions)
//                tick - half-period elapsed
//  Revision    : 1.0  initial release
// ============================================================================
module spi_half_tick #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = $clog2(CLK_DIV + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = C_RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter sits at zero once expired, so tick stays high until reload.
  assign tick = (cnt_q == '0);

endmodule : spi_half_tick
`default_nettype wire

// File: rtl/spi_host.sv
`default_nettype none
// ============================================================================
//  Module      : spi_host
//  Description : SPI mode-0 initiator sending waveform-select commands to the
//                wavegen client. A command accepted over valid/ready is
//                framed as {zeros, cmd} and shifted out MSB first, followed
//                by a minimum chip-select-high gap.
//  Ports       : clk, rst    - system clock, synchronous active-high reset
//                cmd         - command to send
//                cmd_valid   - command offered
//                cmd_ready   - command can be accepted (IDLE only)
//                busy        - frame or gap in progress
//                done        - one-cycle pulse when cs deasserts
//                spi_clk     - SPI clock, idles low
//                mosi        - serial data
//                cs          - chip select, active low
//  Config      : SPI_REPEAT_EN - when defined, the last accepted command is
//                resent after REPEAT_PERIOD consecutive idle cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_host
  import spi_wavegen_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int FRAME_BITS    = FRAME_BITS_DEF,
  parameter int CMD_W         = CMD_W_DEF,
  parameter int CS_GAP        = 4,
  parameter int REPEAT_PERIOD = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             busy,
  output logic             done,
  output logic             spi_clk,
  output logic             mosi,
  output logic             cs
);

  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GAP_W = $clog2(CS_GAP + 1);

  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'(CS_GAP - 1);

  spi_host_state_t         state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic                    cs_q, cs_d;
  logic                    spi_clk_q, spi_clk_d;
  logic                    mosi_q, mosi_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    cmd_ready_q, cmd_ready_d;

  logic                    half_tick;
  logic                    tick_load;
  logic                    repeat_fire;
  logic [CMD_W-1:0]        launch_cmd;
  logic [FRAME_BITS-1:0]   frame;
  logic [FRAME_BITS-1:0]   sr_shift;

  // --------------------------------------------------------------------------
  // Auto-resend of the last command after a long idle period
  // --------------------------------------------------------------------------
`ifdef SPI_REPEAT_EN
  localparam int IDLE_W = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(REPEAT_PERIOD - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              have_cmd_q, have_cmd_d;
  logic [CMD_W-1:0]  last_cmd_q, last_cmd_d;

  // Fires on the REPEAT_PERIOD-th consecutive idle cycle without cmd_valid.
  assign repeat_fire = (state_q == IDLE) && !cmd_valid && have_cmd_q &&
                       (idle_cnt_q == C_IDLE_LAST);
  assign launch_cmd  = cmd_valid ? cmd : last_cmd_q;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    have_cmd_d = have_cmd_q;
    last_cmd_d = last_cmd_q;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        idle_cnt_d = '0;
        have_cmd_d = 1'b1;
        last_cmd_d = cmd;
      end else if (repeat_fire) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q != C_IDLE_LAST) begin
        // Saturates while no command has been seen yet.
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      have_cmd_q <= 1'b0;
      last_cmd_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      have_cmd_q <= have_cmd_d;
      last_cmd_q <= last_cmd_d;
    end
  end
`else
  logic unused_repeat_period;
  assign unused_repeat_period = ^REPEAT_PERIOD;
  assign repeat_fire          = 1'b0;
  assign launch_cmd           = cmd;
`endif

  assign frame    = FRAME_BITS'(launch_cmd);
  assign sr_shift = sr_q << 1;

  // --------------------------------------------------------------------------
  // Half-period timer, restarted on every state change
  // --------------------------------------------------------------------------
  assign tick_load = (state_d != state_q);

  spi_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk  (clk),
    .rst  (rst),
    .load (tick_load),
    .tick (half_tick)
  );

  // --------------------------------------------------------------------------
  // Framing FSM: next state and registered-output values
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_d      = cs_q;
    spi_clk_d = spi_clk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // cmd_ready is high exactly in IDLE, so cmd_valid here is a handshake.
        if (cmd_valid || repeat_fire) begin
          sr_d      = frame;
          bit_cnt_d = C_LAST_BIT;
          cs_d      = 1'b0;
          mosi_d    = frame[FRAME_BITS-1];
          state_d   = LEAD;
        end
      end
      LEAD: begin
        if (half_tick) begin
          spi_clk_d = 1'b1;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (half_tick) begin
          spi_clk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            state_d = TRAIL;
          end else begin
            // Next bit goes out together with the falling edge (mode 0).
            sr_d      = sr_shift;
            mosi_d    = sr_shift[FRAME_BITS-1];
            bit_cnt_d = bit_cnt_q - 1'b1;
            state_d   = LOW;
          end
        end
      end
      LOW: begin
        if (half_tick) begin
          spi_clk_d = 1'b1;
          state_d   = HIGH;
        end
      end
      TRAIL: begin
        if (half_tick) begin
          cs_d      = 1'b1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = C_GAP_LOAD;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      cs_q        <= 1'b1;
      spi_clk_q   <= 1'b0;
      mosi_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      cs_q        <= cs_d;
      spi_clk_q   <= spi_clk_d;
      mosi_q      <= mosi_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cs        = cs_q;
  assign spi_clk   = spi_clk_q;
  assign mosi      = mosi_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;

endmodule : spi_host
`default_nettype wire

// File: tb/tb_spi_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_host
//  Description : Directed self-checking bench for spi_host. Instance u_div2
//                runs with CLK_DIV=2, instance u_div1 with CLK_DIV=1; both
//                share clock and reset. With SPI_REPEAT_EN defined the
//                auto-resend behaviour is exercised instead of the handshake
//                scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [3:0] cmd0 = '0;
  logic       valid0 = 1'b0;
  logic       ready0, busy0, done0, sclk0, mosi0, cs0;

  logic [3:0] cmd1 = '0;
  logic       valid1 = 1'b0;
  logic       ready1, busy1, done1, sclk1, mosi1, cs1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spi_host #(
    .CLK_DIV(2), .FRAME_BITS(8), .CMD_W(4), .CS_GAP(4), .REPEAT_PERIOD(50)
  ) u_div2 (
    .clk(clk), .rst(rst), .cmd(cmd0), .cmd_valid(valid0), .cmd_ready(ready0),
    .busy(busy0), .done(done0), .spi_clk(sclk0), .mosi(mosi0), .cs(cs0)
  );

  spi_host #(
    .CLK_DIV(1), .FRAME_BITS(8), .CMD_W(4), .CS_GAP(4), .REPEAT_PERIOD(50)
  ) u_div1 (
    .clk(clk), .rst(rst), .cmd(cmd1), .cmd_valid(valid1), .cmd_ready(ready1),
    .busy(busy1), .done(done1), .spi_clk(sclk1), .mosi(mosi1), .cs(cs1)
  );

  // Observe one frame of the selected instance, one sample per cycle (#1
  // after posedge), starting with the current sample. Returns on the first
  // sample with cs high and busy low after cs has been seen low.
  task automatic measure(input bit sel, input int budget,
                         output logic [7:0] bits, output int cs_low,
                         output int rises, output int toggles,
                         output int dones, output int busy_n,
                         output int ready_bad, output int mode_bad,
                         output int lead_high, output int trail_high,
                         output bit timeout);
    logic s_sclk, s_mosi, s_cs, s_busy, s_ready, s_done;
    logic p_sclk, p_mosi;
    bit   seen, fin;
    bits = '0; cs_low = 0; rises = 0; toggles = 0; dones = 0; busy_n = 0;
    ready_bad = 0; mode_bad = 0; lead_high = 0; trail_high = 0;
    seen = 1'b0; fin = 1'b0;
    p_sclk = sel ? sclk1 : sclk0;
    p_mosi = sel ? mosi1 : mosi0;
    for (int i = 0; i < budget; i++) begin
      s_sclk  = sel ? sclk1  : sclk0;
      s_mosi  = sel ? mosi1  : mosi0;
      s_cs    = sel ? cs1    : cs0;
      s_busy  = sel ? busy1  : busy0;
      s_ready = sel ? ready1 : ready0;
      s_done  = sel ? done1  : done0;
      if (!s_cs) begin
        cs_low++;
        seen = 1'b1;
      end else if (seen) begin
        trail_high++;
      end else begin
        lead_high++;
      end
      if (s_sclk && !p_sclk) begin
        bits = {bits[6:0], s_mosi};
        rises++;
      end
      if (s_sclk != p_sclk) toggles++;
      if ((s_mosi != p_mosi) && s_sclk) mode_bad++;
      if (s_done) dones++;
      if (s_busy) busy_n++;
      if (s_busy && s_ready) ready_bad++;
      p_sclk = s_sclk;
      p_mosi = s_mosi;
      if (seen && s_cs && !s_busy) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    timeout = !fin;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cs0, sclk0, mosi0, ready0, busy0, done0} !== 6'b100100)
      $display("FAIL reset_div2: got %b expected 100100",
               {cs0, sclk0, mosi0, ready0, busy0, done0});
    else n_pass++;
    n_checks++;
    if ({cs1, sclk1, mosi1, ready1, busy1, done1} !== 6'b100100)
      $display("FAIL reset_div1: got %b expected 100100",
               {cs1, sclk1, mosi1, ready1, busy1, done1});
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifndef SPI_REPEAT_EN
  task automatic test_single_frame();
    logic [7:0] bits;
    int cl, ri, tg, dn, bn, rb, mb, lh, th;
    bit to;
    cmd0 = 4'h5; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    n_checks++;
    if (cs0 !== 1'b0) $display("FAIL single_latency: cs got %b expected 0", cs0);
    else n_pass++;
    measure(1'b0, 200, bits, cl, ri, tg, dn, bn, rb, mb, lh, th, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL single_timeout: frame did not complete");
    else n_pass++;
    n_checks++;
    if (bits !== 8'h05) $display("FAIL single_bits: got %h expected 05", bits);
    else n_pass++;
    n_checks++;
    if (ri !== 8) $display("FAIL single_rises: got %0d expected 8", ri);
    else n_pass++;
    n_checks++;
    if (cl !== 34) $display("FAIL single_cs_low: got %0d expected 34", cl);
    else n_pass++;
    n_checks++;
    if (dn !== 1) $display("FAIL single_done: got %0d pulses expected 1", dn);
    else n_pass++;
    n_checks++;
    if (bn !== 38) $display("FAIL single_busy: got %0d cycles expected 38", bn);
    else n_pass++;
    n_checks++;
    if (tg !== 16) $display("FAIL single_toggles: got %0d expected 16", tg);
    else n_pass++;
    n_checks++;
    if (mb !== 0) $display("FAIL single_mode0: mosi moved with spi_clk high %0d times expected 0", mb);
    else n_pass++;
    n_checks++;
    if (th !== 5) $display("FAIL single_gap: cs high got %0d expected 5", th);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    int cl, ri, tg, dn, bn, rb, mb, lh, th;
    bit to;
    cmd0 = 4'h3; valid0 = 1'b1;
    @(posedge clk); #1;
    cmd0 = 4'hC;
    measure(1'b0, 200, bits, cl, ri, tg, dn, bn, rb, mb, lh, th, to);
    n_checks++;
    if (bits !== 8'h03 || to) $display("FAIL b2b_first_bits: got %h timeout %0d expected 03", bits, to);
    else n_pass++;
    n_checks++;
    if (rb !== 0) $display("FAIL b2b_first_ready: ready high while busy %0d cycles expected 0", rb);
    else n_pass++;
    n_checks++;
    if (th !== 5) $display("FAIL b2b_gap: cs high got %0d expected 5", th);
    else n_pass++;
    @(posedge clk); #1;
    valid0 = 1'b0;
    n_checks++;
    if (cs0 !== 1'b0) $display("FAIL b2b_reaccept: cs got %b expected 0", cs0);
    else n_pass++;
    measure(1'b0, 200, bits, cl, ri, tg, dn, bn, rb, mb, lh, th, to);
    n_checks++;
    if (bits !== 8'h0C || to) $display("FAIL b2b_second_bits: got %h timeout %0d expected 0c", bits, to);
    else n_pass++;
    n_checks++;
    if (rb !== 0) $display("FAIL b2b_second_ready: ready high while busy %0d cycles expected 0", rb);
    else n_pass++;
  endtask

  task automatic test_cmd_change();
    logic [7:0] bits;
    int cl, ri, tg, dn, bn, rb, mb, lh, th;
    bit to;
    int extra;
    cmd0 = 4'h5; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    fork
      measure(1'b0, 200, bits, cl, ri, tg, dn, bn, rb, mb, lh, th, to);
      begin
        repeat (6) @(posedge clk);
        #1;
        cmd0 = 4'hF; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
      end
    join
    n_checks++;
    if (bits !== 8'h05 || to) $display("FAIL change_bits: got %h timeout %0d expected 05", bits, to);
    else n_pass++;
    n_checks++;
    if (dn !== 1) $display("FAIL change_done: got %0d expected 1", dn);
    else n_pass++;
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (!cs0) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL change_no_queue: cs low %0d cycles expected 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] bits;
    int cl, ri, tg, dn, bn, rb, mb, lh, th;
    bit to;
    int  rises, dones;
    logic p_sclk;
    cmd0 = 4'h5; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    rises = 0; dones = 0; p_sclk = sclk0;
    for (int i = 0; i < 200 && rises < 4; i++) begin
      @(posedge clk); #1;
      if (sclk0 && !p_sclk) rises++;
      if (done0) dones++;
      p_sclk = sclk0;
    end
    n_checks++;
    if (rises !== 4) $display("FAIL rstmid_reach: rises got %0d expected 4", rises);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({cs0, sclk0, mosi0, done0, busy0, ready0} !== 6'b100001)
      $display("FAIL rstmid_outputs: got %b expected 100001",
               {cs0, sclk0, mosi0, done0, busy0, ready0});
    else n_pass++;
    @(posedge clk); #1;
    if (done0) dones++;
    n_checks++;
    if (dones !== 0 || cs0 !== 1'b1 || sclk0 !== 1'b0)
      $display("FAIL rstmid_quiet: done %0d cs %b spi_clk %b expected 0 1 0", dones, cs0, sclk0);
    else n_pass++;
    cmd0 = 4'hC; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    measure(1'b0, 200, bits, cl, ri, tg, dn, bn, rb, mb, lh, th, to);
    n_checks++;
    if (bits !== 8'h0C || to) $display("FAIL rstmid_next_bits: got %h timeout %0d expected 0c", bits, to);
    else n_pass++;
    n_checks++;
    if (cl !== 34 || ri !== 8 || dn !== 1)
      $display("FAIL rstmid_next_shape: cs_low %0d rises %0d done %0d expected 34 8 1", cl, ri, dn);
    else n_pass++;
  endtask

  task automatic test_div1();
    logic [7:0] bits;
    int cl, ri, tg, dn, bn, rb, mb, lh, th;
    bit to;
    cmd1 = 4'hA; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    n_checks++;
    if (cs1 !== 1'b0) $display("FAIL div1_latency: cs got %b expected 0", cs1);
    else n_pass++;
    measure(1'b1, 100, bits, cl, ri, tg, dn, bn, rb, mb, lh, th, to);
    n_checks++;
    if (bits !== 8'h0A || to) $display("FAIL div1_bits: got %h timeout %0d expected 0a", bits, to);
    else n_pass++;
    n_checks++;
    if (cl !== 17) $display("FAIL div1_cs_low: got %0d expected 17", cl);
    else n_pass++;
    n_checks++;
    if (tg !== 16 || ri !== 8) $display("FAIL div1_clock: toggles %0d rises %0d expected 16 8", tg, ri);
    else n_pass++;
    n_checks++;
    if (bn !== 21 || dn !== 1) $display("FAIL div1_busy_done: busy %0d done %0d expected 21 1", bn, dn);
    else n_pass++;
    n_checks++;
    if (mb !== 0) $display("FAIL div1_mode0: violations %0d expected 0", mb);
    else n_pass++;
  endtask
`else
  task automatic test_repeat();
    logic [7:0] bits;
    int cl, ri, tg, dn, bn, rb, mb, lh, th;
    bit to;
    int early;
    early = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (!cs0) early++;
    end
    n_checks++;
    if (early !== 0) $display("FAIL repeat_none_before_cmd: cs low %0d cycles expected 0", early);
    else n_pass++;
    cmd0 = 4'h6; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    measure(1'b0, 200, bits, cl, ri, tg, dn, bn, rb, mb, lh, th, to);
    n_checks++;
    if (bits !== 8'h06 || to) $display("FAIL repeat_first_bits: got %h timeout %0d expected 06", bits, to);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      measure(1'b0, 300, bits, cl, ri, tg, dn, bn, rb, mb, lh, th, to);
      n_checks++;
      if (to !== 1'b0) $display("FAIL repeat_timeout: resend %0d never completed", k);
      else n_pass++;
      n_checks++;
      if (lh !== 50) $display("FAIL repeat_period: idle cycles got %0d expected 50", lh);
      else n_pass++;
      n_checks++;
      if (bits !== 8'h06 || cl !== 34 || dn !== 1)
        $display("FAIL repeat_frame: bits %h cs_low %0d done %0d expected 06 34 1", bits, cl, dn);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef SPI_REPEAT_EN
    test_single_frame();
    test_back_to_back();
    test_cmd_change();
    test_reset_mid_frame();
    test_div1();
`else
    test_repeat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_spi_host
`default_nettype wire
